// File: rtl/isr_tracker_pkg.sv
// Shared encodings for the Z80 instruction-boundary tracker: FSM states and prefix bytes.
package isr_tracker_pkg;

  typedef enum logic [2:0] {
    S_NEW  = 3'd0,
    S_CB   = 3'd1,
    S_ED   = 3'd2,
    S_IX   = 3'd3,
    S_IXCB = 3'd4
  } state_t;

  localparam logic [7:0] PREFIX_CB = 8'hCB;
  localparam logic [7:0] PREFIX_DD = 8'hDD;
  localparam logic [7:0] PREFIX_ED = 8'hED;
  localparam logic [7:0] PREFIX_FD = 8'hFD;

  function automatic logic is_index_prefix(input logic [7:0] b);
    return (b == PREFIX_DD) || (b == PREFIX_FD);
  endfunction

endpackage

// File: rtl/isr_tracker_bus_cycle_detect.sv
// Tracks the Z80 M1 fetch, interrupt-acknowledge and non-M1 read windows and emits a
// registered one-clock pulse on the edge after each window closes.
module bus_cycle_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic m1_n,
  input  logic mreq_n,
  input  logic iorq_n,
  input  logic rd_n,
  output logic fetch_capture,
  output logic fetch_done,
  output logic intack_done,
  output logic memrd_done
);

  // Index 0 = M1 fetch, 1 = int-ack, 2 = non-M1 memory read.
  logic [2:0] win;
  logic [2:0] active;
  logic [2:0] done;

  assign win[0] = ~m1_n & ~mreq_n & ~rd_n;
  assign win[1] = ~m1_n & ~iorq_n;
  assign win[2] =  m1_n & ~mreq_n & ~rd_n;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win
      logic open_reg;
      logic block_reg;
      logic done_reg;

      // A window already open when reset releases stays blocked until it closes.
      assign active[gi] = win[gi] & ~block_reg;
      assign done[gi]   = done_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          open_reg  <= 1'b0;
          block_reg <= 1'b1;
          done_reg  <= 1'b0;
        end else begin
          done_reg <= open_reg & ~win[gi];
          open_reg <= active[gi];
          if (!win[gi]) block_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign fetch_capture = active[0];
  assign fetch_done    = done[0];
  assign intack_done   = done[1];
  assign memrd_done    = done[2];

endmodule

// File: rtl/isr_tracker.sv
// Follows Z80 prefix sequences across opcode fetches to flag instruction boundaries and
// whether the most recently completed instruction was an untrap opcode.
module isr_tracker
  import isr_tracker_pkg::*;
#(
  parameter logic [7:0] UNTRAP_OP    = 8'hC3,
  parameter logic [7:0] UNTRAP_ED_OP = 8'h45,
  parameter bit         ENABLE_ED_UT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic [7:0] data_in,
  output logic       new_isr,
  output logic       last_isr_untrap,
  output logic [7:0] opcode_q,
  output logic [2:0] prefix_state
);

  logic   fetch_capture;
  logic   fetch_done;
  logic   intack_done;
  logic   memrd_done;

  state_t     state_reg, state_next;
  logic [1:0] count_reg, count_next;
  logic       untrap_reg, untrap_next;
  logic       new_isr_reg;
  logic [7:0] opcode_reg;
  logic       complete;
  logic       untrap_hit;

  bus_cycle_detect u_bus (
    .clk           (clk),
    .reset_n       (reset_n),
    .m1_n          (m1_n),
    .mreq_n        (mreq_n),
    .iorq_n        (iorq_n),
    .rd_n          (rd_n),
    .fetch_capture (fetch_capture),
    .fetch_done    (fetch_done),
    .intack_done   (intack_done),
    .memrd_done    (memrd_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_NEW;
      count_reg   <= 2'd0;
      untrap_reg  <= 1'b0;
      new_isr_reg <= 1'b1;
      opcode_reg  <= 8'h00;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      untrap_reg  <= untrap_next;
      new_isr_reg <= (state_next == S_NEW);
      if (fetch_capture) opcode_reg <= data_in;
    end
  end

  // The committed byte is the last one captured while the window was open.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    untrap_next = untrap_reg;
    complete    = 1'b0;
    untrap_hit  = ((state_reg == S_NEW) && (opcode_reg == UNTRAP_OP)) ||
                  ((state_reg == S_ED) && (opcode_reg == UNTRAP_ED_OP) && ENABLE_ED_UT);

    if (intack_done) begin
      state_next  = S_NEW;
      count_next  = 2'd0;
      untrap_next = 1'b0;
    end else if (fetch_done) begin
      count_next = 2'd0;
      case (state_reg)
        S_NEW: begin
          if (opcode_reg == PREFIX_CB)          state_next = S_CB;
          else if (opcode_reg == PREFIX_ED)     state_next = S_ED;
          else if (is_index_prefix(opcode_reg)) state_next = S_IX;
          else                                  complete   = 1'b1;
        end
        S_CB, S_ED: complete = 1'b1;
        S_IX: begin
          if (is_index_prefix(opcode_reg))  state_next = S_IX;
          else if (opcode_reg == PREFIX_ED) state_next = S_ED;
          else if (opcode_reg == PREFIX_CB) state_next = S_IXCB;
          else                              complete   = 1'b1;
        end
        default: state_next = S_NEW;
      endcase
      if (complete) begin
        state_next  = S_NEW;
        untrap_next = untrap_hit;
      end
    end else if (memrd_done && (state_reg == S_IXCB)) begin
      // DD/FD CB d op: displacement then opcode arrive as plain memory reads.
      if (count_reg == 2'd1) begin
        state_next  = S_NEW;
        count_next  = 2'd0;
        untrap_next = 1'b0;
      end else begin
        count_next = count_reg + 2'd1;
      end
    end
  end

  assign new_isr         = new_isr_reg;
  assign last_isr_untrap = untrap_reg;
  assign opcode_q        = opcode_reg;
  assign prefix_state    = state_reg;

endmodule
